// File: rtl/alu_pkg.sv
// Shared constants and payload type for the ALU issue stage.
// Opcode/funct encodings follow the MIPS32 base ISA.
package alu_pkg;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [11:0] control;
        logic [4:0]  dest;
        logic        wen;
        logic        illegal;
    } issue_t;

    function automatic logic [11:0] onehot(input int idx);
        logic [11:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS instruction into an ALU issue payload.
// Unknown encodings fall back to add with no register write.
import alu_pkg::*;

module alu_issue_decode (
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output issue_t      payload
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign op       = inst[31:26];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign sa       = inst[10:6];
    assign funct    = inst[5:0];
    assign imm      = inst[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Opcode/funct to operands, one-hot op, and destination
    always_comb begin
        payload.src1    = rs_value;
        payload.src2    = rt_value;
        payload.control = onehot(ALU_ADD);
        payload.dest    = rd;
        payload.wen     = 1'b1;
        payload.illegal = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL: begin
                        payload.control = onehot(ALU_SLL);
                        payload.src1    = rt_value;
                        payload.src2    = {27'b0, sa};
                    end
                    FN_SRL: begin
                        payload.control = onehot(ALU_SRL);
                        payload.src1    = rt_value;
                        payload.src2    = {27'b0, sa};
                    end
                    FN_SRA: begin
                        payload.control = onehot(ALU_SRA);
                        payload.src1    = rt_value;
                        payload.src2    = {27'b0, sa};
                    end
                    FN_SLLV: begin
                        payload.control = onehot(ALU_SLL);
                        payload.src1    = rt_value;
                        payload.src2    = rs_value;
                    end
                    FN_SRLV: begin
                        payload.control = onehot(ALU_SRL);
                        payload.src1    = rt_value;
                        payload.src2    = rs_value;
                    end
                    FN_SRAV: begin
                        payload.control = onehot(ALU_SRA);
                        payload.src1    = rt_value;
                        payload.src2    = rs_value;
                    end
                    FN_ADDU: payload.control = onehot(ALU_ADD);
                    FN_SUBU: payload.control = onehot(ALU_SUB);
                    FN_AND:  payload.control = onehot(ALU_AND);
                    FN_OR:   payload.control = onehot(ALU_OR);
                    FN_XOR:  payload.control = onehot(ALU_XOR);
                    FN_NOR:  payload.control = onehot(ALU_NOR);
                    FN_SLT:  payload.control = onehot(ALU_SLT);
                    FN_SLTU: payload.control = onehot(ALU_SLTU);
                    default: payload.illegal = 1'b1;
                endcase
            end
            OP_ADDIU, OP_LW: begin
                payload.src2 = imm_sext;
                payload.dest = rt;
            end
            OP_SW: begin
                payload.src2 = imm_sext;
                payload.dest = rt;
                payload.wen  = 1'b0;
            end
            OP_SLTI: begin
                payload.control = onehot(ALU_SLT);
                payload.src2    = imm_sext;
                payload.dest    = rt;
            end
            OP_SLTIU: begin
                payload.control = onehot(ALU_SLTU);
                payload.src2    = imm_sext;
                payload.dest    = rt;
            end
            OP_ANDI: begin
                payload.control = onehot(ALU_AND);
                payload.src2    = imm_zext;
                payload.dest    = rt;
            end
            OP_ORI: begin
                payload.control = onehot(ALU_OR);
                payload.src2    = imm_zext;
                payload.dest    = rt;
            end
            OP_XORI: begin
                payload.control = onehot(ALU_XOR);
                payload.src2    = imm_zext;
                payload.dest    = rt;
            end
            OP_LUI: begin
                payload.control = onehot(ALU_LUI);
                payload.src1    = 32'h0;
                payload.src2    = {imm, 16'h0000};
                payload.dest    = rt;
            end
            OP_JAL: begin
                payload.src1 = pc;
                payload.src2 = 32'd8;
                payload.dest = 5'd31;
            end
            default: payload.illegal = 1'b1;
        endcase
        if (payload.illegal) begin
            payload.control = onehot(ALU_ADD);
            payload.wen     = 1'b0;
        end
        if (payload.dest == 5'd0) begin
            payload.wen = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-ALU issue stage with a main+skid buffered handshake.
// Define ALU_ISSUE_ILLEGAL_EN to expose the out_illegal flag.
import alu_pkg::*;

module alu_issue_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs_value,
    input  logic [31:0] in_rt_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [11:0] alu_control,
    output logic [4:0]  out_dest,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic        out_illegal,
`endif
    output logic        out_wen
);

    issue_t dec;
    issue_t main_q;
    issue_t skid_q;
    logic   main_v;
    logic   skid_v;
    logic   accept;
    logic   drain;

    alu_issue_decode u_decode (
        .inst     (in_inst),
        .pc       (in_pc),
        .rs_value (in_rs_value),
        .rt_value (in_rt_value),
        .payload  (dec)
    );

    assign in_ready = !skid_v;
    assign accept   = in_valid && in_ready;
    assign drain    = main_v && out_ready;

    // Two-entry FIFO: main feeds the outputs, skid absorbs one stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain) begin
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_v <= 1'b0;
            end
        end else if (!main_v) begin
            if (accept) begin
                main_q <= dec;
                main_v <= 1'b1;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign out_valid   = main_v;
    assign alu_src1    = main_q.src1;
    assign alu_src2    = main_q.src2;
    assign alu_control = main_q.control;
    assign out_dest    = main_q.dest;
    assign out_wen     = main_q.wen;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal = main_q.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vector bench for alu_issue_stage.
// Covers decode table, stall/skid ordering, flush and async reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs_value;
    logic [31:0] in_rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [11:0] alu_control;
    logic [4:0]  out_dest;
    logic        out_wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs_value (in_rs_value),
        .in_rt_value (in_rt_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_control (alu_control),
        .out_dest    (out_dest),
`ifdef ALU_ISSUE_ILLEGAL_EN
        .out_illegal (out_illegal),
`endif
        .out_wen     (out_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [11:0] ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        wen;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_inst     = v.inst;
        in_pc       = v.pc;
        in_rs_value = v.rs;
        in_rt_value = v.rt;
    endtask

    task automatic chk_out(input vec_t v);
        chk({v.name, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({v.name, ".ctrl"}, {20'b0, alu_control}, {20'b0, v.ctrl});
        chk({v.name, ".src1"}, alu_src1, v.src1);
        chk({v.name, ".src2"}, alu_src2, v.src2);
        chk({v.name, ".dest"}, {27'b0, out_dest}, {27'b0, v.dest});
        chk({v.name, ".wen"}, {31'b0, out_wen}, {31'b0, v.wen});
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk({v.name, ".ill"}, {31'b0, out_illegal}, {31'b0, v.ill});
`endif
    endtask

    initial begin
        vecs[0]  = '{"addu",  32'h00221821, 32'h0, 32'd5, 32'd7,
                     12'h800, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
        vecs[1]  = '{"sll",   32'h00022140, 32'h0, 32'h0, 32'h0000000F,
                     12'h008, 32'h0000000F, 32'd5, 5'd4, 1'b1, 1'b0};
        vecs[2]  = '{"lui",   32'h3C051234, 32'h0, 32'h0, 32'h0,
                     12'h001, 32'h0, 32'h12340000, 5'd5, 1'b1, 1'b0};
        vecs[3]  = '{"ori",   32'h3426FFFF, 32'h0, 32'h10, 32'h0,
                     12'h020, 32'h10, 32'h0000FFFF, 5'd6, 1'b1, 1'b0};
        vecs[4]  = '{"addiu", 32'h2407FFFF, 32'h0, 32'd3, 32'h0,
                     12'h800, 32'd3, 32'hFFFFFFFF, 5'd7, 1'b1, 1'b0};
        vecs[5]  = '{"sw",    32'hAC220004, 32'h0, 32'h100, 32'h55,
                     12'h800, 32'h100, 32'd4, 5'd2, 1'b0, 1'b0};
        vecs[6]  = '{"jal",   32'h0C000010, 32'h400, 32'h0, 32'h0,
                     12'h800, 32'h400, 32'd8, 5'd31, 1'b1, 1'b0};
        vecs[7]  = '{"subu0", 32'h00220023, 32'h0, 32'd9, 32'd4,
                     12'h400, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{"srav",  32'h00221807, 32'h0, 32'd3, 32'h80000000,
                     12'h002, 32'h80000000, 32'd3, 5'd3, 1'b1, 1'b0};
        vecs[9]  = '{"nor",   32'h00221827, 32'h0, 32'hA, 32'hB,
                     12'h040, 32'hA, 32'hB, 5'd3, 1'b1, 1'b0};
        vecs[10] = '{"sltiu", 32'h2C238000, 32'h0, 32'd1, 32'h0,
                     12'h100, 32'd1, 32'hFFFF8000, 5'd3, 1'b1, 1'b0};
        vecs[11] = '{"xori",  32'h38238000, 32'h0, 32'd1, 32'h0,
                     12'h010, 32'd1, 32'h00008000, 5'd3, 1'b1, 1'b0};
        vecs[12] = '{"slt",   32'h0022182A, 32'h0, 32'd2, 32'd6,
                     12'h200, 32'd2, 32'd6, 5'd3, 1'b1, 1'b0};
        vecs[13] = '{"illeg", 32'hFC221800, 32'h0, 32'd1, 32'd2,
                     12'h800, 32'd1, 32'd2, 5'd3, 1'b0, 1'b1};
    end

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in_inst     = '0;
        in_pc       = '0;
        in_rs_value = '0;
        in_rt_value = '0;
        #1;
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.ready", {31'b0, in_ready}, 32'd1);
        chk("rst.src1", alu_src1, 32'd0);
        chk("rst.src2", alu_src2, 32'd0);
        chk("rst.ctrl", {20'b0, alu_control}, 32'd0);
        chk("rst.dest", {27'b0, out_dest}, 32'd0);
        chk("rst.wen", {31'b0, out_wen}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            chk({vecs[i].name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk_out(vecs[i]);
        end
        @(posedge clk);
        #1;
        chk("drain.valid", {31'b0, out_valid}, 32'd0);

        // Stall: A to main, B to skid, C held off
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall.rdyB", {31'b0, in_ready}, 32'd1);
        drive(vecs[1]);
        @(negedge clk);
        chk("stall.rdyC", {31'b0, in_ready}, 32'd0);
        drive(vecs[2]);
        chk_out(vecs[0]);
        @(negedge clk);
        chk("stall.hold", {31'b0, in_ready}, 32'd0);
        chk_out(vecs[0]);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_out(vecs[1]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out(vecs[2]);
        @(posedge clk);
        #1;
        chk("stall.empty", {31'b0, out_valid}, 32'd0);

        // Flush with skid full
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[4]);
        @(negedge clk);
        chk("fl.full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl.valid", {31'b0, out_valid}, 32'd0);
        chk("fl.ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fl.none", {31'b0, out_valid}, 32'd0);

        // Flush beats a simultaneous accept
        @(negedge clk);
        drive(vecs[5]);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flacc.valid", {31'b0, out_valid}, 32'd0);

        // Async reset mid-operation
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[6]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[7]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar.pre", {31'b0, out_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar.valid", {31'b0, out_valid}, 32'd0);
        chk("ar.ready", {31'b0, in_ready}, 32'd1);
        chk("ar.ctrl", {20'b0, alu_control}, 32'd0);
        chk("ar.src1", alu_src1, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ar.after", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage that produces the ALU operand/control interface (alu_src1, alu_src2, 12-bit one-hot alu_control) from a fetched MIPS instruction and its register-file read values. It sits between the decode/register-read logic and the ALU. It provides a registered valid/ready boundary with a two-entry skid buffer, so the pipeline can stall without combinational ready paths.

## Interface
Parameters:
- None; all widths are fixed at 32-bit data and 12-bit control.

Ports:
- clk  input  1  single clock; all state on the rising edge
- resetn  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  instruction presented
- in_ready  output  1  stage can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  32  instruction address
- in_rs_value  input  32  GPR[rs]
- in_rt_value  input  32  GPR[rt]
- out_valid  output  1  issued ALU operation valid
- out_ready  input  1  ALU/EX consumer accepts
- alu_src1  output  32  ALU operand 1; for shifts, the value being shifted
- alu_src2  output  32  ALU operand 2; for shifts, the amount in [4:0]; for LUI, the upper immediate
- alu_control  output  12  one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui
- out_dest  output  5  destination GPR
- out_wen  output  1  destination write enable
- out_illegal  output  1  undecodable instruction (only with ALU_ISSUE_ILLEGAL_EN)

## Operation
- Decode:
  - ADDU/ADDIU/LW/SW map to add.
  - SUBU→sub; SLT/SLTI→slt; SLTU/SLTIU→sltu.
  - AND/ANDI→and; OR/ORI→or; XOR/XORI→xor; NOR→nor.
  - SLL/SRL/SRA and the V forms map to sll/srl/sra; LUI→lui; JAL→add.
- Operands:
  - R-type ALU ops: src1=rs, src2=rt.
  - Immediate shifts: src1=rt, src2={27'b0,sa}. Variable shifts: src1=rt, src2=rs.
  - ADDIU/SLTI/SLTIU/LW/SW: src2 = sign-extended imm16. ANDI/ORI/XORI: src2 = zero-extended imm16.
  - LUI: src1=0, src2={imm16,16'b0}.
  - JAL: src1=pc, src2=8.
- Destination:
  - R-type: rd. I-type: rt. JAL: 31.
  - SW: out_wen=0.
  - out_wen is forced to 0 when the destination is 0.
- Exactly one alu_control bit is set whenever out_valid=1.
- Buffering:
  - Main register plus skid register.
  - in_ready = skid empty (registered).
  - An accept with main empty, or main draining this cycle, loads main. Otherwise it loads skid.
  - When main drains and skid is full, skid moves to main.
- Ordering is strictly FIFO.
- Sustained throughput is one instruction per cycle with out_ready held high.

## Timing
- Reset values: out_valid=0, in_ready=1, alu_src1/alu_src2=0, alu_control=0, out_dest=0, out_wen=0, out_illegal=0.
- Latency: an instruction accepted at edge N appears at out_valid after edge N, i.e. one cycle.
- Handshake:
  - Transfer occurs when valid&ready are both high at an edge.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Inputs are sampled only on an in-side transfer.
- Full: a second instruction accepted while stalled fills skid. in_ready falls the following cycle and rises the cycle after skid empties.
- Simultaneous drain and accept with skid full is not possible, since in_ready=0.
- Simultaneous drain and accept with skid empty: the new instruction goes to main with no bubble.
- flush:
  - Clears both entries at the next edge.
  - Takes priority over a simultaneous accept, which is discarded.
  - out_valid=0 and in_ready=1 the cycle after.
- resetn low mid-operation: immediate asynchronous return to the reset values; in-flight entries are lost.

## Configuration
- ALU_ISSUE_ILLEGAL_EN defined:
  - Unrecognised opcode/funct issues with alu_control=add, out_wen=0, out_illegal=1.
- ALU_ISSUE_ILLEGAL_EN undefined:
  - The out_illegal port is absent.
  - Unrecognised instructions issue as add with out_wen=0 and are otherwise silent.

## Structure
- Shared package alu_pkg:
  - Bit-index constants for the 12 alu_control positions.
  - Opcode and funct constants.
  - Typedef for the issue payload (src1, src2, control, dest, wen, illegal).
- Sub-module alu_issue_decode: purely combinational inst/rs/rt/pc → payload.
- The top level holds the skid buffer and handshake only.

## Test plan
- Reset, then issue ADDU inst 0x00221821 with rs=5, rt=7, out_ready=1:
  - Next cycle: out_valid=1, alu_control=0x800, src1=5, src2=7, out_dest=3, out_wen=1.
- SLL inst 0x00022140, rt=0x0000000F:
  - alu_control=0x008, src1=0x0000000F, src2=5, out_dest=4.
- LUI inst 0x3C051234, then ORI inst 0x3426FFFF with rs=0x10:
  - LUI: alu_control=0x001, src2=0x12340000.
  - ORI: alu_control=0x020, src2=0x0000FFFF, out_dest=6.
- ADDIU inst 0x2407FFFF:
  - src2=0xFFFFFFFF, alu_control=0x800.
- Stall:
  - Hold out_ready=0 and send 3 back-to-back instructions: A and B are accepted, then in_ready=0 and C is held.
  - Raise out_ready: outputs A, B, C in order with no bubble.
  - Raise flush with skid full: out_valid=0 and in_ready=1 next cycle, nothing issued.
